regfile_scoreboard: RTL and testbench

- Parametrised general-purpose register file for the Simple RISC Machine datapath: NREGS registers of width n, one write port, two combinational read ports.
- Carries a per-register busy (scoreboard) bit. Issue logic sets the bit when an instruction targeting that register is dispatched; writeback clears it.
- Replaces the single-register building block in the datapath. Adds asynchronous reset, same-cycle write-through bypass and hazard status.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/load_register_ar.sv | 23 ++
 rtl/regfile_scoreboard.sv | 67 ++++++
 tb/tb_regfile_scoreboard.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the Simple RISC Machine register file.
// Holds the default configuration used by the top module and its storage cells.
`timescale 1ns/1ps
package regfile_pkg;

  localparam int REGFILE_N     = 16;
  localparam int REGFILE_NREGS = 8;
  localparam int REGFILE_AW    = $clog2(REGFILE_NREGS);

  typedef logic [REGFILE_AW-1:0] reg_idx_t;

endpackage

// File: rtl/load_register_ar.sv
// n-bit load-enabled register with asynchronous active-low clear.
// One instance per architectural register inside regfile_scoreboard.
`timescale 1ns/1ps
module load_register_ar
  import regfile_pkg::*;
#(
  parameter int n = REGFILE_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [n-1:0] d,
  output logic [n-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard, two combinational read
// ports and same-cycle writeback bypass on both data and busy status.
`timescale 1ns/1ps
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int n     = REGFILE_N,
  parameter  int NREGS = REGFILE_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write,
  input  logic [AW-1:0]    writenum,
  input  logic [n-1:0]     data_in,
  input  logic             issue,
  input  logic [AW-1:0]    issue_num,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [n-1:0]     data_a,
  output logic [n-1:0]     data_b,
  output logic             busy_a,
  output logic             busy_b,
  output logic [NREGS-1:0] busy_vec
);

  logic [n-1:0]     regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             hit_a;
  logic             hit_b;

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    load_register_ar #(.n(n)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (write && (writenum == AW'(i))),
      .d     (data_in),
      .q     (regs[i])
    );
  end

  // A new claim is younger than the retiring write, so issue beats writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (issue && (issue_num == AW'(i)))
          busy[i] <= 1'b1;
        else if (write && (writenum == AW'(i)))
          busy[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    hit_a  = write && (writenum == readnum_a);
    hit_b  = write && (writenum == readnum_b);
    data_a = hit_a ? data_in : regs[readnum_a];
    data_b = hit_b ? data_in : regs[readnum_b];
    busy_a = busy[readnum_a] && !hit_a;
    busy_b = busy[readnum_b] && !hit_b;
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared each cycle against an array-based model.
`timescale 1ns/1ps
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        write;
  logic [2:0]  writenum;
  logic [15:0] data_in;
  logic        issue;
  logic [2:0]  issue_num;
  logic [2:0]  readnum_a;
  logic [2:0]  readnum_b;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic        busy_a;
  logic        busy_b;
  logic [7:0]  busy_vec;

  logic        write2;
  logic [3:0]  writenum2;
  logic [31:0] data_in2;
  logic        issue2;
  logic [3:0]  issue_num2;
  logic [3:0]  readnum_a2;
  logic [3:0]  readnum_b2;
  logic [31:0] data_a2;
  logic [31:0] data_b2;
  logic        busy_a2;
  logic        busy_b2;
  logic [15:0] busy_vec2;

  int total = 0;
  int bad   = 0;

  regfile_scoreboard dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .write     (write),
    .writenum  (writenum),
    .data_in   (data_in),
    .issue     (issue),
    .issue_num (issue_num),
    .readnum_a (readnum_a),
    .readnum_b (readnum_b),
    .data_a    (data_a),
    .data_b    (data_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .busy_vec  (busy_vec)
  );

  regfile_scoreboard #(.n(32), .NREGS(16)) dut_wide (
    .clk       (clk),
    .rst_n     (rst_n),
    .write     (write2),
    .writenum  (writenum2),
    .data_in   (data_in2),
    .issue     (issue2),
    .issue_num (issue_num2),
    .readnum_a (readnum_a2),
    .readnum_b (readnum_b2),
    .data_a    (data_a2),
    .data_b    (data_b2),
    .busy_a    (busy_a2),
    .busy_b    (busy_b2),
    .busy_vec  (busy_vec2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arrays of register contents and claim flags.
  logic [15:0] m_reg  [8];
  logic        m_busy [8];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_reg[i]  <= 16'h0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      if (write) m_reg[writenum] <= data_in;
      for (int i = 0; i < 8; i++) begin
        if (issue && int'(issue_num) == i)
          m_busy[i] <= 1'b1;
        else if (write && int'(writenum) == i)
          m_busy[i] <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [2:0] wn, input logic [15:0] d,
                               input logic iss, input logic [2:0] isn,
                               input logic [2:0] ra, input logic [2:0] rb);
    @(posedge clk);
    #1;
    write     = w;
    writenum  = wn;
    data_in   = d;
    issue     = iss;
    issue_num = isn;
    readnum_a = ra;
    readnum_b = rb;
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  logic [7:0]  exp_vec;
  logic [15:0] exp_a;
  logic [15:0] exp_b;
  logic        exp_ba;
  logic        exp_bb;

  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) exp_vec[i] = m_busy[i];
    exp_a  = (write && writenum == readnum_a) ? data_in : m_reg[readnum_a];
    exp_b  = (write && writenum == readnum_b) ? data_in : m_reg[readnum_b];
    exp_ba = m_busy[readnum_a] && !(write && writenum == readnum_a);
    exp_bb = m_busy[readnum_b] && !(write && writenum == readnum_b);
    checkOutput("cyc_data_a",   32'(data_a),   32'(exp_a));
    checkOutput("cyc_data_b",   32'(data_b),   32'(exp_b));
    checkOutput("cyc_busy_a",   32'(busy_a),   32'(exp_ba));
    checkOutput("cyc_busy_b",   32'(busy_b),   32'(exp_bb));
    checkOutput("cyc_busy_vec", 32'(busy_vec), 32'(exp_vec));
  end

  initial begin
    rst_n = 1'b0;
    write = 0; writenum = 0; data_in = 0; issue = 0; issue_num = 0;
    readnum_a = 0; readnum_b = 0;
    write2 = 0; writenum2 = 0; data_in2 = 0; issue2 = 0; issue_num2 = 0;
    readnum_a2 = 0; readnum_b2 = 0;
    #1;
    checkOutput("rst_data_a",   32'(data_a),    32'h0);
    checkOutput("rst_busy_vec", 32'(busy_vec),  32'h0);
    checkOutput("rst_wide_vec", 32'(busy_vec2), 32'h0);
    #11;
    rst_n = 1'b1;

    // Claim and write R3, then pull reset mid-cycle.
    applyStimulus(1, 3, 16'hBEEF, 1, 3, 3, 3);
    applyStimulus(0, 0, 16'h0, 0, 0, 3, 3);
    checkOutput("r3_written",  32'(data_a),   32'h0000BEEF);
    checkOutput("r3_claimed",  32'(busy_vec), 32'h08);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_data", 32'(data_a),   32'h0);
    checkOutput("async_rst_vec",  32'(busy_vec), 32'h0);
    checkOutput("async_rst_busy", 32'(busy_a),   32'h0);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 0, 16'h0, 0, 0, 3, 3);
    checkOutput("post_rst_r3", 32'(data_a), 32'h0);

    // Plain writes and reads.
    applyStimulus(1, 5, 16'h1234, 0, 0, 0, 0);
    applyStimulus(1, 2, 16'hABCD, 0, 0, 0, 0);
    applyStimulus(0, 0, 16'h0, 0, 0, 5, 2);
    checkOutput("read_r5", 32'(data_a), 32'h1234);
    checkOutput("read_r2", 32'(data_b), 32'hABCD);
    for (int i = 0; i < 8; i++) begin
      if (i != 5 && i != 2) begin
        applyStimulus(0, 0, 16'h0, 0, 0, 3'(i), 3'(i));
        checkOutput("untouched_zero", 32'(data_a), 32'h0);
      end
    end

    // Same-cycle bypass on both ports.
    applyStimulus(1, 6, 16'h00FF, 0, 0, 6, 6);
    checkOutput("bypass_a", 32'(data_a), 32'h00FF);
    checkOutput("bypass_b", 32'(data_b), 32'h00FF);

    // Claim R4, then retire it.
    applyStimulus(0, 0, 16'h0, 1, 4, 4, 4);
    applyStimulus(0, 0, 16'h0, 0, 0, 4, 4);
    checkOutput("r4_vec",   32'(busy_vec), 32'h10);
    checkOutput("r4_busy",  32'(busy_a),   32'h1);
    applyStimulus(1, 4, 16'h0007, 0, 0, 4, 4);
    checkOutput("r4_bypass_busy", 32'(busy_a),   32'h0);
    checkOutput("r4_vec_held",    32'(busy_vec), 32'h10);
    applyStimulus(0, 0, 16'h0, 0, 0, 4, 4);
    checkOutput("r4_vec_clear", 32'(busy_vec), 32'h0);
    checkOutput("r4_data",      32'(data_a),   32'h0007);

    // Set wins over same-cycle clear.
    applyStimulus(0, 0, 16'h0, 1, 1, 1, 1);
    applyStimulus(1, 1, 16'h5A5A, 1, 1, 1, 1);
    applyStimulus(0, 0, 16'h0, 0, 0, 1, 1);
    checkOutput("setclr_vec",  32'(busy_vec), 32'h02);
    checkOutput("setclr_busy", 32'(busy_a),   32'h1);
    checkOutput("setclr_data", 32'(data_a),   32'h5A5A);

    // Wider configuration: 32-bit data, 16 registers.
    @(posedge clk); #1;
    issue2 = 1; issue_num2 = 15; readnum_a2 = 15;
    @(posedge clk); #1;
    issue2 = 0;
    checkOutput("wide_vec_set", 32'(busy_vec2), 32'h8000);
    checkOutput("wide_busy_a",  32'(busy_a2),   32'h1);
    write2 = 1; writenum2 = 15; data_in2 = 32'hDEADBEEF;
    #1;
    checkOutput("wide_bypass", data_a2, 32'hDEADBEEF);
    @(posedge clk); #1;
    write2 = 0; data_in2 = 0;
    checkOutput("wide_vec_clr", 32'(busy_vec2), 32'h0);
    checkOutput("wide_data",    data_a2,        32'hDEADBEEF);

    // Randomized traffic with occasional mid-cycle resets.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(1'($urandom), 3'($urandom), 16'($urandom),
                    ($urandom_range(0, 2) == 0), 3'($urandom),
                    3'($urandom), 3'($urandom));
      if ($urandom_range(0, 63) == 0) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
    end

    @(posedge clk); #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
